// File: rtl/rgmii_rx_iddr_decoder_if.sv
// RGMII receive pins, mode select and the rebuilt GMII byte stream with in-band status.
interface rgmii_rx_iddr_decoder_if;
  logic [3:0] rgmii_rxd;
  logic       rgmii_rx_ctl;
  logic       mii_select;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic       rx_ce;
  logic       link_up;
  logic [1:0] link_speed;
  logic       full_duplex;

  modport master (
    output rgmii_rxd, rgmii_rx_ctl, mii_select,
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er, rx_ce, link_up, link_speed, full_duplex
  );

  modport slave (
    input  rgmii_rxd, rgmii_rx_ctl, mii_select,
    output gmii_rxd, gmii_rx_dv, gmii_rx_er, rx_ce, link_up, link_speed, full_duplex
  );
endinterface

// File: rtl/rgmii_rx_iddr_decoder.sv
// RGMII receive front end: DDR capture of RXD/RX_CTL, realignment to the rising edge,
// GMII byte rebuild (1000 DDR or 10/100 nibble) and in-band link status decode.
module rgmii_rx_iddr_decoder #(
  parameter string TARGET      = "GENERIC",
  parameter string IODDR_STYLE = "IODDR2"
) (
  input  logic                   clk,
  input  logic                   rst,
  rgmii_rx_iddr_decoder_if.slave bus
);

  typedef enum logic [1:0] { ST_WAIT_IDLE, ST_IDLE, ST_RX } state_t;

  // The two-clock IODDR2 takes its falling sample on the rising edge of the inverted clock
  localparam bit FALL_ON_CLK_C1 = (TARGET == "XILINX") && (IODDR_STYLE == "IODDR2");

  logic [4:0] rise_p0;
  logic [4:0] fall_p0;
  logic       vld_p0;

  // Stage p0: rising and falling edge capture of {rxd, ctl}
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      rise_p0 <= {bus.rgmii_rxd, bus.rgmii_rx_ctl};
      vld_p0  <= 1'b1;
    end
  end

  generate
    if (FALL_ON_CLK_C1) begin : g_fall_c1
      logic clk_c1;
      assign clk_c1 = ~clk;
      always_ff @(posedge clk_c1) fall_p0 <= {bus.rgmii_rxd, bus.rgmii_rx_ctl};
    end else begin : g_fall_neg
      always_ff @(negedge clk) fall_p0 <= {bus.rgmii_rxd, bus.rgmii_rx_ctl};
    end
  endgenerate

  logic [3:0] d1_rxd_p1;
  logic [3:0] d2_rxd_p1;
  logic       d1_ctl_p1;
  logic       d2_ctl_p1;
  logic       vld_p1;

  // Stage p1: both samples of one bit period presented together on the rising edge.
  // vld_p1 stays low for pairs flushed by reset so they cannot end WAIT_IDLE early.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_rxd_p1 <= '0;
      d2_rxd_p1 <= '0;
      d1_ctl_p1 <= 1'b0;
      d2_ctl_p1 <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      {d1_rxd_p1, d1_ctl_p1} <= rise_p0;
      {d2_rxd_p1, d2_ctl_p1} <= fall_p0;
      vld_p1                 <= vld_p0;
    end
  end

  logic       dv_p1;
  logic       er_p1;
  logic [7:0] raw_p1;
  logic       status_pair_p1;

  assign dv_p1          = d1_ctl_p1;
  assign er_p1          = d1_ctl_p1 ^ d2_ctl_p1;
  assign raw_p1         = {d2_rxd_p1, d1_rxd_p1};
  assign status_pair_p1 = !d1_ctl_p1 && !d2_ctl_p1 && (d1_rxd_p1 == d2_rxd_p1);

  state_t     state_q, state_d;
  logic       mii_mode_q, mii_mode_d;
  logic       phase_q, phase_d;
  logic       ce_tog_q, ce_tog_d;
  logic [3:0] low_nib_q, low_nib_d;
  logic       low_er_q, low_er_d;

  logic [7:0] rxd_p2, rxd_d;
  logic       dv_p2, dv_d;
  logic       er_p2, er_d;
  logic       ce_p2, ce_d;
  logic       link_up_p2, link_up_d;
  logic [1:0] link_speed_p2, link_speed_d;
  logic       full_duplex_p2, full_duplex_d;

  always_comb begin
    state_d       = state_q;
    mii_mode_d    = mii_mode_q;
    phase_d       = phase_q;
    ce_tog_d      = ce_tog_q;
    low_nib_d     = low_nib_q;
    low_er_d      = low_er_q;
    rxd_d         = '0;
    dv_d          = 1'b0;
    er_d          = 1'b0;
    ce_d          = 1'b0;
    link_up_d     = link_up_p2;
    link_speed_d  = link_speed_p2;
    full_duplex_d = full_duplex_p2;

    if (vld_p1) begin
      // Outside a frame: raw byte, carrier/false-carrier flag, strobe paced by the mode
      rxd_d    = raw_p1;
      er_d     = er_p1;
      ce_d     = !mii_mode_q || ce_tog_q;
      ce_tog_d = !ce_tog_q;

      case (state_q)
        ST_WAIT_IDLE: begin
          if (!dv_p1) state_d = ST_IDLE;
        end

        ST_IDLE: begin
          mii_mode_d = bus.mii_select;
          ce_d       = !bus.mii_select || ce_tog_q;
          if (dv_p1) begin
            state_d = ST_RX;
            dv_d    = 1'b1;
            if (bus.mii_select) begin
              low_nib_d = d1_rxd_p1;
              low_er_d  = er_p1;
              phase_d   = 1'b1;
              ce_d      = 1'b0;
            end else begin
              ce_d = 1'b1;
            end
          end else if (status_pair_p1) begin
            link_up_d     = d1_rxd_p1[0];
            link_speed_d  = d1_rxd_p1[2:1];
            full_duplex_d = d1_rxd_p1[3];
          end
        end

        ST_RX: begin
          if (dv_p1) begin
            dv_d = 1'b1;
            if (!mii_mode_q) begin
              ce_d = 1'b1;
            end else if (!phase_q) begin
              low_nib_d = d1_rxd_p1;
              low_er_d  = er_p1;
              phase_d   = 1'b1;
              ce_d      = 1'b0;
            end else begin
              rxd_d   = {d1_rxd_p1, low_nib_q};
              er_d    = er_p1 || low_er_q;
              ce_d    = 1'b1;
              phase_d = 1'b0;
            end
          end else begin
            state_d = ST_IDLE;
            // A frame ending on an odd nibble still delivers it, flagged as errored
            if (mii_mode_q && phase_q) begin
              rxd_d   = {4'h0, low_nib_q};
              dv_d    = 1'b1;
              er_d    = 1'b1;
              ce_d    = 1'b1;
              phase_d = 1'b0;
            end
          end
        end

        default: state_d = ST_WAIT_IDLE;
      endcase
    end
  end

  // Stage p2: decoder state and registered GMII/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_WAIT_IDLE;
      mii_mode_q     <= 1'b0;
      phase_q        <= 1'b0;
      ce_tog_q       <= 1'b0;
      rxd_p2         <= '0;
      dv_p2          <= 1'b0;
      er_p2          <= 1'b0;
      ce_p2          <= 1'b0;
      link_up_p2     <= 1'b0;
      link_speed_p2  <= 2'b00;
      full_duplex_p2 <= 1'b0;
    end else begin
      state_q        <= state_d;
      mii_mode_q     <= mii_mode_d;
      phase_q        <= phase_d;
      ce_tog_q       <= ce_tog_d;
      rxd_p2         <= rxd_d;
      dv_p2          <= dv_d;
      er_p2          <= er_d;
      ce_p2          <= ce_d;
      link_up_p2     <= link_up_d;
      link_speed_p2  <= link_speed_d;
      full_duplex_p2 <= full_duplex_d;
    end
    low_nib_q <= low_nib_d;
    low_er_q  <= low_er_d;
  end

  assign bus.gmii_rxd    = rxd_p2;
  assign bus.gmii_rx_dv  = dv_p2;
  assign bus.gmii_rx_er  = er_p2;
  assign bus.rx_ce       = ce_p2;
  assign bus.link_up     = link_up_p2;
  assign bus.link_speed  = link_speed_p2;
  assign bus.full_duplex = full_duplex_p2;

endmodule

// File: doc/rgmii_rx_iddr_decoder.md
# rgmii_rx_iddr_decoder

Receive-side counterpart to the generic output DDR register used on the RGMII transmit path. The block captures the 4-bit RGMII receive data and RX_CTL on both edges of the receive clock. It realigns both samples to the rising edge and rebuilds a GMII-style byte stream with valid/error flags, supporting 1000 Mb/s DDR and 10/100 Mb/s nibble modes. It also decodes RGMII in-band link status and sits between the PHY pins and the Ethernet MAC receive logic.

## Interface
- TARGET, "GENERIC": capture primitive selection ("SIM", "GENERIC", "XILINX", "ALTERA"). All behaviour below is defined by the GENERIC model; vendor variants must match it cycle-for-cycle at the outputs.
- IODDR_STYLE, "IODDR2": Xilinx primitive style ("IODDR" or "IODDR2"). Ignored for other targets.
- clk  input  1  RGMII receive clock (125/25/2.5 MHz). Both edges are used for capture only.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- rgmii_rxd  input  4  DDR receive data. Bits [3:0] arrive on the rising edge, bits [7:4] on the falling edge.
- rgmii_rx_ctl  input  1  DDR control. RX_DV arrives on the rising edge; RX_DV XOR RX_ER arrives on the falling edge.
- mii_select  input  1  1 = 10/100 nibble mode, 0 = gigabit mode. Sampled only in IDLE.
- gmii_rxd  output  8  received byte.
- gmii_rx_dv  output  1  byte valid (data valid).
- gmii_rx_er  output  1  byte error.
- rx_ce  output  1  byte strobe. gmii_* outputs are meaningful only when rx_ce=1.
- link_up  output  1  in-band status: link up.
- link_speed  output  2  in-band status: 00 = 10M, 01 = 100M, 10 = 1000M.
- full_duplex  output  1  in-band status: full duplex.

## Operation
- Capture stage, generic model:
  - On the rising edge, sample r = {rxd, ctl}.
  - On the falling edge, sample f = {rxd, ctl}.
  - On the next rising edge, present d1 = r and d2 = f as a pair.
  - Pair semantics: d1 is the rising sample of edge k; d2 is the falling sample between edge k and edge k+1.
- Decode of each pair:
  - dv = d1.ctl
  - er = d1.ctl XOR d2.ctl
- Byte assembly, gigabit mode: byte = {d2.rxd, d1.rxd}. rx_ce=1 every cycle.
- Byte assembly, MII mode:
  - Only d1.rxd is used.
  - The first nibble with dv=1 after IDLE is the low nibble; the next nibble is the high nibble.
  - rx_ce pulses on every second cycle, when the high nibble completes.
  - The er flag of a byte is the OR of the er flags of both nibbles.
- Decoder FSM states:
  - WAIT_IDLE: entered on reset. All pairs are discarded until one pair with dv=0 is seen, which moves the FSM to IDLE. This drops the remainder of any frame that was in flight during reset.
  - IDLE:
    - Latch mii_select into the mode register.
    - A pair with dv=1 moves the FSM to RX.
    - In gigabit mode, that first byte is emitted in the same step. In MII mode, the low nibble is stored and the phase is set to 1.
  - RX:
    - Assemble bytes as above.
    - A pair with dv=0 moves the FSM to IDLE.
    - If dv drops while the MII phase is 1, emit one final byte {4'h0, low nibble} with dv=1 and er=1, with rx_ce=1 in the cycle where dv is seen low.
- Outputs during IDLE and WAIT_IDLE:
  - gmii_rx_dv=0.
  - gmii_rx_er=er (carrier/false-carrier indication).
  - gmii_rxd = raw byte.
  - rx_ce follows mode: 1 in gigabit mode; in MII mode it toggles.
- In-band status:
  - A status update happens only in IDLE, on a pair with d1.ctl=0, d2.ctl=0, and d1.rxd == d2.rxd.
  - On update: link_up=rxd[0], link_speed=rxd[2:1], full_duplex=rxd[3].
  - Pairs that fail any of these checks leave the status unchanged.
- mii_select changes during RX have no effect until the next IDLE.

## Timing
- Capture latency: 1 rising edge from the edge-k sample to the (d1, d2) pair.
- Decode latency: 1 further edge. A rising-edge sample at edge k appears on gmii_* after edge k+2.
- In MII mode, a byte appears 2 edges after its high nibble's rising sample.
- Status outputs update with the same 2-edge latency.
- Reset values, all outputs:
  - gmii_rxd=0, gmii_rx_dv=0, gmii_rx_er=0, rx_ce=0.
  - link_up=0, link_speed=2'b00, full_duplex=0.
  - MII phase=0, FSM=WAIT_IDLE.
  - The capture registers clear on the first rising edge with rst=1. The falling-edge register is cleared through the rising-edge transfer.
- Reset asserted mid-frame: outputs are 0 after that edge. After rst deasserts, no byte is emitted until dv=0 has been observed once.
- Simultaneous rst and dv=1 pair: rst wins.

## Test plan
- Gigabit frame, rxd rise/fall nibbles 5/5 ×7 then 5/D, ctl 1/1:
  - Required: 8 bytes 0x55×7, 0xD5, with dv=1, er=0, rx_ce=1 every cycle, first byte 2 edges after the first sample.
  - Then ctl 0/0: dv=0 on the next output cycle.
- Gigabit error, ctl rise/fall = 1/0 on byte 3 of a frame:
  - Required: byte 3 has dv=1, er=1; the neighbouring bytes have er=0.
- MII mode (mii_select=1), rising nibbles 5,5,5,D, ctl=1 throughout:
  - Required: bytes 0x55 then 0xD5, with rx_ce=1 on alternate cycles only.
  - Then dv drops after a single extra nibble 0x3: required final byte 0x03 with dv=1, er=1.
- In-band status, IDLE, ctl 0/0, rxd 0xD both edges:
  - Required: link_up=1, link_speed=2'b10, full_duplex=1.
  - Then rxd rise/fall 0xD/0x1: required no change in status.
- Reset mid-frame:
  - Assert rst for 1 cycle during a gigabit frame of 20 bytes: required all outputs 0.
  - Required: no dv=1 output until the frame ends and a new frame starts; the new frame's first byte is emitted intact.
- Mode change during RX:
  - Toggle mii_select mid-frame: required the frame completes in its original mode, and the new mode applies to the next frame.
